// File: rtl/axi_sram_slave.sv
// AXI3 slave that serves one read or write burst at a time from a local word-wide SRAM.
// INCR bursts only, one-word address step, index wraps modulo the array size.
module axi_sram_slave #(
    parameter int AW     = 12,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [2:0] {IDLE, RWAIT, RDATA, WDATA, WRESP} state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and rvalid/rdata hold steady until accepted.
    state_t        state;
    logic [AW-1:0] addr;
    logic [3:0]    len;
    logic [3:0]    beat;
    logic [2:0]    lat_cnt;
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          mem_we;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            addr    <= '0;
            len     <= '0;
            beat    <= '0;
            lat_cnt <= '0;
            rid     <= '0;
            bid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (awvalid) begin
                        bid   <= awid;
                        addr  <= awaddr[AW+1:2];
                        len   <= awlen;
                        beat  <= '0;
                        state <= WDATA;
                    end else if (arvalid) begin
                        rid     <= arid;
                        addr    <= araddr[AW+1:2];
                        len     <= arlen;
                        beat    <= '0;
                        lat_cnt <= 3'(RD_LAT);
                        state   <= (RD_LAT == 0) ? RDATA : RWAIT;
                    end
                end
                RWAIT: begin
                    // Leave on the cycle whose decrement brings the counter to 1.
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt <= 3'd2) state <= RDATA;
                end
                RDATA: begin
                    if (rready) begin
                        addr <= addr + AW'(1);
                        beat <= beat + 4'd1;
                        if (beat == len) state <= IDLE;
                    end
                end
                WDATA: begin
                    if (wvalid) begin
                        addr <= addr + AW'(1);
                        beat <= beat + 4'd1;
                        if (beat == len) state <= WRESP;
                    end
                end
                WRESP: begin
                    if (bready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory is never cleared; bytes written before a reset stay put.
    assign mem_we = resetn && (state == WDATA) && wvalid;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign awready = resetn && (state == IDLE);
    assign arready = resetn && (state == IDLE) && !awvalid;
    assign rvalid  = (state == RDATA);
    assign rlast   = rvalid && (beat == len);
    assign rdata   = rvalid ? mem[addr] : '0;
    assign rresp   = 2'b00;
    assign wready  = (state == WDATA);
    assign bvalid  = (state == WRESP);
    assign bresp   = 2'b00;

    logic unused_inputs;
    assign unused_inputs = ^{araddr[31:AW+2], araddr[1:0], awaddr[31:AW+2], awaddr[1:0],
                             arsize, arburst, awsize, awburst, wid, wlast};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: a reference memory model feeds an expected-data queue that is
// drained as read beats are accepted; two extra instances cover the read-latency settings.
module tb_axi_sram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [3:0]  arid;   logic [31:0] araddr; logic [3:0] arlen;
    logic [2:0]  arsize; logic [1:0]  arburst; logic arvalid, arready;
    logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;   logic [31:0] awaddr; logic [3:0] awlen;
    logic [2:0]  awsize; logic [1:0]  awburst; logic awvalid, awready;
    logic [3:0]  wid;    logic [31:0] wdata;  logic [3:0] wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;    logic [1:0]  bresp;  logic bvalid, bready;

    logic tie0 = 1'b0;
    logic tie1 = 1'b1;
    logic arvalid_l3, arvalid_l0;
    logic l3_arready, l3_rlast, l3_rvalid, l3_awready, l3_wready, l3_bvalid;
    logic [3:0] l3_rid, l3_bid; logic [31:0] l3_rdata; logic [1:0] l3_rresp, l3_bresp;
    logic l0_arready, l0_rlast, l0_rvalid, l0_awready, l0_wready, l0_bvalid;
    logic [3:0] l0_rid, l0_bid; logic [31:0] l0_rdata; logic [1:0] l0_rresp, l0_bresp;

    axi_sram_slave #(.AW(12), .RD_LAT(1)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi_sram_slave #(.AW(12), .RD_LAT(3)) dut_l3 (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid_l3), .arready(l3_arready),
        .rid(l3_rid), .rdata(l3_rdata), .rresp(l3_rresp), .rlast(l3_rlast), .rvalid(l3_rvalid),
        .rready(tie1),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(tie0), .awready(l3_awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(tie0), .wready(l3_wready),
        .bid(l3_bid), .bresp(l3_bresp), .bvalid(l3_bvalid), .bready(tie1)
    );

    axi_sram_slave #(.AW(12), .RD_LAT(0)) dut_l0 (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid_l0), .arready(l0_arready),
        .rid(l0_rid), .rdata(l0_rdata), .rresp(l0_rresp), .rlast(l0_rlast), .rvalid(l0_rvalid),
        .rready(tie1),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(tie0), .awready(l0_awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(tie0), .wready(l0_wready),
        .bid(l0_bid), .bresp(l0_bresp), .bvalid(l0_bvalid), .bready(tie1)
    );

    logic [31:0] exp_q[$];
    logic [31:0] model_mem [int];
    int          compares = 0;
    int          mismatches = 0;
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [3:0]  rd_id [16];
    logic [1:0]  rd_resp [16];
    int          rd_n;
    int          stable_err;

    function automatic int word_idx(input logic [31:0] addr, input int b);
        return (int'(addr >> 2) + b) % 4096;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] addr, input int b);
        int idx = word_idx(addr, b);
        return model_mem.exists(idx) ? model_mem[idx] : 'x;
    endfunction

    function automatic logic [31:0] pop_exp();
        return (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (awready) break;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_beats(input logic [31:0] addr, input int nb);
        for (int b = 0; b < nb; b++) begin
            int idx = word_idx(addr, b);
            logic [31:0] merged = model_mem.exists(idx) ? model_mem[idx] : 'x;
            for (int i = 0; i < 4; i++)
                if (sbuf[b][i]) merged[8*i +: 8] = wbuf[b][8*i +: 8];
            model_mem[idx] = merged;
            wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == nb - 1); wvalid = 1'b1;
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_phase(output logic [3:0] bid_o, output logic [1:0] bresp_o);
        bid_o = 'x; bresp_o = 'x;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bvalid) begin bid_o = bid; bresp_o = bresp; break; end
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             output logic [3:0] bid_o, output logic [1:0] bresp_o);
        aw_phase(id, addr, len);
        w_beats(addr, int'(len) + 1);
        b_phase(bid_o, bresp_o);
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        for (int b = 0; b <= int'(len); b++) exp_q.push_back(model_rd(addr, b));
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (arready) break;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic r_phase(input int nb, input bit throttle);
        logic        held = 1'b0;
        logic [31:0] held_data = '0;
        rd_n = 0; stable_err = 0;
        for (int cyc = 0; cyc < 300 && rd_n < nb; cyc++) begin
            rready = throttle ? (cyc % 3 == 2) : 1'b1;
            @(negedge clk);
            if (rvalid) begin
                if (held && rdata !== held_data) stable_err++;
                if (rready) begin
                    rd_data[rd_n] = rdata; rd_last[rd_n] = rlast;
                    rd_id[rd_n] = rid; rd_resp[rd_n] = rresp;
                    rd_n++; held = 1'b0;
                end else begin
                    held = 1'b1; held_data = rdata;
                end
            end
            @(posedge clk); #1;
        end
        rready = 1'b0;
    endtask

    task automatic measure_lat(input int sel, output int lat);
        arid = 4'd0; araddr = 32'h0; arlen = 4'd0; rready = 1'b1;
        case (sel)
            0:       arvalid = 1'b1;
            1:       arvalid_l3 = 1'b1;
            default: arvalid_l0 = 1'b1;
        endcase
        @(posedge clk); #1;
        arvalid = 1'b0; arvalid_l3 = 1'b0; arvalid_l0 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (sel == 0 ? rvalid : (sel == 1 ? l3_rvalid : l0_rvalid)) begin lat = n; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compares++;
        if ({awready, arready, rvalid, wready, bvalid, rlast} !== 6'b0) begin
            mismatches++;
            $display("FAIL reset_handshakes: got %b expected 000000",
                     {awready, arready, rvalid, wready, bvalid, rlast});
        end
        compares++;
        if ({rid, bid, rdata} !== 40'h0) begin
            mismatches++;
            $display("FAIL reset_ids_data: got %h expected 0", {rid, bid, rdata});
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        compares++;
        if ({awready, arready} !== 2'b11) begin
            mismatches++;
            $display("FAIL idle_ready: got %b expected 11", {awready, arready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_rw();
        logic [3:0] b_id; logic [1:0] b_resp; logic [31:0] e;
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        axi_write(4'd1, 32'h10, 4'd0, b_id, b_resp);
        compares++;
        if ({b_id, b_resp} !== {4'd1, 2'b00}) begin
            mismatches++; $display("FAIL single_b: got id %h resp %h expected id 1 resp 0", b_id, b_resp);
        end
        ar_phase(4'd0, 32'h10, 4'd0);
        r_phase(1, 1'b0);
        e = pop_exp();
        compares++;
        if (rd_n !== 1) begin mismatches++; $display("FAIL single_beats: got %0d expected 1", rd_n); end
        compares++;
        if (rd_data[0] !== e) begin
            mismatches++; $display("FAIL single_rdata: got %h expected %h", rd_data[0], e);
        end
        compares++;
        if (rd_data[0] !== 32'hDEADBEEF) begin
            mismatches++; $display("FAIL single_rdata_const: got %h expected deadbeef", rd_data[0]);
        end
        compares++;
        if ({rd_last[0], rd_id[0], rd_resp[0]} !== {1'b1, 4'd0, 2'b00}) begin
            mismatches++;
            $display("FAIL single_r_ctrl: got last %b id %h resp %h expected last 1 id 0 resp 0",
                     rd_last[0], rd_id[0], rd_resp[0]);
        end
        exp_q.delete();
    endtask

    task automatic test_strobe();
        logic [3:0] b_id; logic [1:0] b_resp; logic [31:0] e;
        wbuf[0] = 32'h0000AB00; sbuf[0] = 4'b0010;
        axi_write(4'd2, 32'h10, 4'd0, b_id, b_resp);
        ar_phase(4'd3, 32'h10, 4'd0);
        r_phase(1, 1'b0);
        e = pop_exp();
        compares++;
        if (rd_data[0] !== e) begin
            mismatches++; $display("FAIL strobe_model: got %h expected %h", rd_data[0], e);
        end
        compares++;
        if (rd_data[0] !== 32'hDEADABEF) begin
            mismatches++; $display("FAIL strobe_const: got %h expected deadabef", rd_data[0]);
        end
        exp_q.delete();
    endtask

    task automatic test_burst_throttle();
        logic [3:0] b_id; logic [1:0] b_resp; logic [31:0] e;
        for (int b = 0; b < 4; b++) begin wbuf[b] = 32'(b + 1); sbuf[b] = 4'hF; end
        axi_write(4'd4, 32'h40, 4'd3, b_id, b_resp);
        compares++;
        if (b_id !== 4'd4) begin mismatches++; $display("FAIL burst_bid: got %h expected 4", b_id); end
        ar_phase(4'd9, 32'h40, 4'd3);
        r_phase(4, 1'b1);
        compares++;
        if (rd_n !== 4) begin mismatches++; $display("FAIL burst_beats: got %0d expected 4", rd_n); end
        for (int b = 0; b < 4; b++) begin
            e = pop_exp();
            compares++;
            if (rd_data[b] !== e || rd_data[b] !== 32'(b + 1)) begin
                mismatches++; $display("FAIL burst_data[%0d]: got %h expected %h", b, rd_data[b], e);
            end
            compares++;
            if (rd_last[b] !== 1'(b == 3)) begin
                mismatches++; $display("FAIL burst_rlast[%0d]: got %b expected %b", b, rd_last[b], b == 3);
            end
        end
        compares++;
        if (stable_err !== 0) begin
            mismatches++; $display("FAIL burst_hold: got %0d changes expected 0", stable_err);
        end
        exp_q.delete();
    endtask

    task automatic test_priority();
        logic [3:0] b_id; logic [1:0] b_resp; logic [31:0] e;
        awid = 4'd5; awaddr = 32'h80; awlen = 4'd0; awvalid = 1'b1;
        arid = 4'd6; araddr = 32'h80; arlen = 4'd0; arvalid = 1'b1;
        @(negedge clk);
        compares++;
        if ({awready, arready} !== 2'b10) begin
            mismatches++; $display("FAIL prio_ready: got %b expected 10", {awready, arready});
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        wbuf[0] = $urandom; sbuf[0] = 4'hF;
        w_beats(32'h80, 1);
        exp_q.push_back(model_rd(32'h80, 0));
        @(negedge clk);
        compares++;
        if (arready !== 1'b0) begin mismatches++; $display("FAIL prio_wresp_arready: got %b expected 0", arready); end
        b_phase(b_id, b_resp);
        compares++;
        if (b_id !== 4'd5) begin mismatches++; $display("FAIL prio_bid: got %h expected 5", b_id); end
        @(negedge clk);
        compares++;
        if (arready !== 1'b1) begin mismatches++; $display("FAIL prio_ar_after: got %b expected 1", arready); end
        @(posedge clk); #1;
        arvalid = 1'b0;
        r_phase(1, 1'b0);
        e = pop_exp();
        compares++;
        if (rd_data[0] !== e || rd_id[0] !== 4'd6) begin
            mismatches++;
            $display("FAIL prio_read: got %h id %h expected %h id 6", rd_data[0], rd_id[0], e);
        end
        exp_q.delete();
    endtask

    task automatic test_latency();
        int lat;
        measure_lat(0, lat);
        compares++;
        if (lat !== 2) begin mismatches++; $display("FAIL lat_rd1: got %0d expected 2", lat); end
        measure_lat(1, lat);
        compares++;
        if (lat !== 3) begin mismatches++; $display("FAIL lat_rd3: got %0d expected 3", lat); end
        measure_lat(2, lat);
        compares++;
        if (lat !== 1) begin mismatches++; $display("FAIL lat_rd0: got %0d expected 1", lat); end
    endtask

    task automatic test_wrap();
        logic [3:0] b_id; logic [1:0] b_resp; logic [31:0] e;
        for (int b = 0; b < 16; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'hF; end
        axi_write(4'($urandom_range(0, 15)), 32'h3FF0, 4'd15, b_id, b_resp);
        ar_phase(4'($urandom_range(0, 15)), 32'h3FF0, 4'd15);
        r_phase(16, 1'b0);
        compares++;
        if (rd_n !== 16) begin mismatches++; $display("FAIL wrap_beats: got %0d expected 16", rd_n); end
        for (int b = 0; b < 16; b++) begin
            e = pop_exp();
            compares++;
            if (rd_data[b] !== e) begin
                mismatches++; $display("FAIL wrap_data[%0d]: got %h expected %h", b, rd_data[b], e);
            end
        end
        compares++;
        if ({rd_last[0], rd_last[15]} !== 2'b01) begin
            mismatches++; $display("FAIL wrap_rlast: got %b expected 01", {rd_last[0], rd_last[15]});
        end
        exp_q.delete();
        ar_phase(4'd0, 32'h3, 4'd0);
        r_phase(1, 1'b0);
        e = pop_exp();
        compares++;
        if (rd_data[0] !== e || rd_data[0] !== wbuf[4]) begin
            mismatches++; $display("FAIL wrap_word0: got %h expected %h", rd_data[0], wbuf[4]);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] b_id; logic [1:0] b_resp; logic [31:0] e;
        for (int b = 0; b < 4; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'hF; end
        axi_write(4'd7, 32'h100, 4'd3, b_id, b_resp);
        ar_phase(4'd8, 32'h100, 4'd3);
        rready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rvalid) break;
        end
        e = pop_exp();
        compares++;
        if (rdata !== e) begin mismatches++; $display("FAIL rst_first_beat: got %h expected %h", rdata, e); end
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        compares++;
        if ({rvalid, arready, awready} !== 3'b000) begin
            mismatches++;
            $display("FAIL rst_drop: got %b expected 000", {rvalid, arready, awready});
        end
        resetn = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        ar_phase(4'd2, 32'h104, 4'd0);
        r_phase(1, 1'b0);
        e = pop_exp();
        compares++;
        if (rd_data[0] !== e || rd_id[0] !== 4'd2) begin
            mismatches++;
            $display("FAIL rst_after_read: got %h id %h expected %h id 2", rd_data[0], rd_id[0], e);
        end
        exp_q.delete();
        // Abort a write burst after two beats; the written words must survive the reset.
        for (int b = 0; b < 2; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'hF; end
        aw_phase(4'd3, 32'h200, 4'd3);
        w_beats(32'h200, 2);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        ar_phase(4'd1, 32'h200, 4'd1);
        r_phase(2, 1'b0);
        for (int b = 0; b < 2; b++) begin
            e = pop_exp();
            compares++;
            if (rd_data[b] !== e) begin
                mismatches++; $display("FAIL rst_partial[%0d]: got %h expected %h", b, rd_data[b], e);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        resetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid_l3 = 1'b0; arvalid_l0 = 1'b0;
        test_reset();
        test_single_rw();
        test_strobe();
        test_burst_throttle();
        test_priority();
        test_latency();
        test_wrap();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
